// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU run sequencer.
//   state_t           : sequencer state encoding
//   IMEM/DMEM_*       : word sizes and the matching address shifts
//   HALT_WORD_DEFAULT : jal x0,0, the halt encoding seen when the CPU spins
//   clamp_len         : limits a requested word count to a memory depth
//   after_load        : where to go once the program is in memory
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_CAP,
    ST_DUMP_OUT,
    ST_DONE
  } state_t;

  localparam int unsigned IMEM_WORD_BYTES = 4;
  localparam int unsigned DMEM_WORD_BYTES = 8;
  localparam int unsigned IMEM_SHIFT      = $clog2(IMEM_WORD_BYTES);
  localparam int unsigned DMEM_SHIFT      = $clog2(DMEM_WORD_BYTES);

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_006F;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input int unsigned lim);
    return (32'(len) > lim) ? 8'(lim) : len;
  endfunction

  // A zero run budget skips RUN; a zero dump length skips the dump.
  function automatic state_t after_load(input logic run_zero, input logic dump_zero);
    if (!run_zero)  return ST_RUN;
    if (!dump_zero) return ST_DUMP_RD;
    return ST_DONE;
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Run-budget counter: a loadable down-counter for the remaining budget and an
// up-counter of cycles actually run.
//   clk, rst        : clock, synchronous active-high reset
//   load, load_val  : restart with a new budget (clears count)
//   step            : one enabled CPU cycle elapsed
//   count           : cycles run since the last load
//   expire          : the current step is the last one of the budget
//   empty           : no budget remaining
module run_cycle_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             expire,
  output logic             empty
);

  logic [CNT_W-1:0] remain;

  always_ff @(posedge clk) begin
    if (rst) begin
      remain <= '0;
      count  <= '0;
    end else if (load) begin
      remain <= load_val;
      count  <= '0;
    end else if (step && (remain != '0)) begin
      remain <= remain - CNT_W'(1);
      count  <= count + CNT_W'(1);
    end
  end

  assign expire = (remain == CNT_W'(1));
  assign empty  = (remain == '0);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Run controller for the single-cycle RISC-V cpu: loads a program into
// instruction memory, runs the CPU for a cycle budget, then streams a window
// of data memory out.
//   clk, rst                          : clock, synchronous active-high reset
//   start, prog_len, run_cycles,
//   dump_len                          : job request (sampled in IDLE)
//   ld_valid/ld_data/ld_ready         : program load stream
//   imem_addr/imem_wen/imem_wdata     : instruction-memory write port
//   dmem_addr/dmem_ren/dmem_rdata     : data-memory read port (1-cycle latency)
//   cpu_arst_n, cpu_enable            : CPU reset release and run enable
//   instr_obs                         : fetched instruction (halt detect only)
//   dump_valid/dump_data/dump_ready   : data dump stream
//   busy, done, cycles_run            : status
//   halted                            : sticky halt flag (halt detect only)
// Optional feature: define CPU_SEQ_HALT_DETECT_EN to end RUN early when the
// CPU fetches HALT_WORD.
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 128,
  parameter int unsigned CNT_W      = 32,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       prog_len,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [7:0]       dump_len,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic [63:0]      imem_addr,
  output logic             imem_wen,
  output logic [31:0]      imem_wdata,
  output logic [63:0]      dmem_addr,
  output logic             dmem_ren,
  input  logic [63:0]      dmem_rdata,
  output logic             cpu_arst_n,
  output logic             cpu_enable,
  input  logic [31:0]      instr_obs,
  output logic             dump_valid,
  output logic [63:0]      dump_data,
  input  logic             dump_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles_run
`ifdef CPU_SEQ_HALT_DETECT_EN
  ,
  output logic             halted
`endif
);

  state_t     state, state_next;
  logic [7:0] plen, dlen, idx, didx;
  logic [7:0] plen_in, dlen_in;
  logic       cnt_load, cnt_step, cnt_expire, cnt_empty;
  logic       halt_hit;

  assign plen_in  = clamp_len(prog_len, IMEM_WORDS);
  assign dlen_in  = clamp_len(dump_len, DMEM_WORDS);
  assign cnt_load = (state == ST_IDLE) && start;
  assign cnt_step = (state == ST_RUN);

`ifdef CPU_SEQ_HALT_DETECT_EN
  assign halt_hit = (instr_obs == HALT_WORD);

  // Sticky until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst)                                halted <= 1'b0;
    else if (cnt_load)                      halted <= 1'b0;
    else if ((state == ST_RUN) && halt_hit) halted <= 1'b1;
  end
`else
  logic unused_halt;
  assign unused_halt = ^{instr_obs, HALT_WORD};
  assign halt_hit    = 1'b0;
`endif

  run_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (run_cycles),
    .step     (cnt_step),
    .count    (cycles_run),
    .expire   (cnt_expire),
    .empty    (cnt_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) begin
        state_next = (plen_in == 8'd0) ? after_load(run_cycles == '0, dlen_in == 8'd0)
                                       : ST_LOAD;
      end
      ST_LOAD: if (ld_valid && (idx == plen - 8'd1)) begin
        state_next = after_load(cnt_empty, dlen == 8'd0);
      end
      ST_RUN: if (cnt_expire || halt_hit) begin
        state_next = (dlen == 8'd0) ? ST_DONE : ST_DUMP_RD;
      end
      ST_DUMP_RD:  state_next = ST_DUMP_CAP;
      ST_DUMP_CAP: state_next = ST_DUMP_OUT;
      ST_DUMP_OUT: if (dump_ready) begin
        state_next = (didx == dlen - 8'd1) ? ST_DONE : ST_DUMP_RD;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; load-port signals pass the stream straight through.
  always_comb begin
    ld_ready   = 1'b0;
    imem_wen   = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    dmem_ren   = 1'b0;
    dmem_addr  = '0;
    cpu_enable = 1'b0;
    dump_valid = 1'b0;
    done       = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_LOAD: begin
        ld_ready   = 1'b1;
        imem_wen   = ld_valid;
        imem_addr  = 64'(idx) << IMEM_SHIFT;
        imem_wdata = ld_data;
      end
      ST_RUN: cpu_enable = 1'b1;
      ST_DUMP_RD: begin
        dmem_ren  = 1'b1;
        dmem_addr = 64'(didx) << DMEM_SHIFT;
      end
      ST_DUMP_OUT: dump_valid = 1'b1;
      ST_DONE:     done       = 1'b1;
      default: ;
    endcase
  end

  // Job registers, indices, CPU reset release and dump capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      plen       <= '0;
      dlen       <= '0;
      idx        <= '0;
      didx       <= '0;
      cpu_arst_n <= 1'b0;
      dump_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          plen       <= plen_in;
          dlen       <= dlen_in;
          idx        <= '0;
          didx       <= '0;
          // An empty program leaves the load phase immediately.
          cpu_arst_n <= (plen_in == 8'd0);
        end
        ST_LOAD: if (ld_valid) begin
          idx <= idx + 8'd1;
          if (state_next != ST_LOAD) cpu_arst_n <= 1'b1;
        end
        ST_DUMP_CAP: dump_data <= dmem_rdata;
        ST_DUMP_OUT: if (dump_ready) didx <= didx + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer with simple instruction and data
// memory models. Build with CPU_SEQ_HALT_DETECT_EN to also cover halt detect.
module tb_cpu_run_sequencer;

  localparam int unsigned CNT_W  = 32;
  localparam int          BUDGET = 2000;

  logic             clk, rst, start;
  logic [7:0]       prog_len, dump_len;
  logic [CNT_W-1:0] run_cycles;
  logic             ld_valid, ld_ready;
  logic [31:0]      ld_data;
  logic [63:0]      imem_addr, dmem_addr, dmem_rdata, dump_data;
  logic             imem_wen, dmem_ren;
  logic [31:0]      imem_wdata, instr_obs;
  logic             cpu_arst_n, cpu_enable;
  logic             dump_valid, dump_ready, busy, done;
  logic [CNT_W-1:0] cycles_run;
`ifdef CPU_SEQ_HALT_DETECT_EN
  logic             halted;
`endif

  cpu_run_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .dump_len   (dump_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_wdata (imem_wdata),
    .dmem_addr  (dmem_addr),
    .dmem_ren   (dmem_ren),
    .dmem_rdata (dmem_rdata),
    .cpu_arst_n (cpu_arst_n),
    .cpu_enable (cpu_enable),
    .instr_obs  (instr_obs),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_ready (dump_ready),
    .busy       (busy),
    .done       (done),
    .cycles_run (cycles_run)
`ifdef CPU_SEQ_HALT_DETECT_EN
    ,
    .halted     (halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: synchronous write, one-cycle read latency.
  logic [31:0] imem_m [128];
  logic [63:0] dmem_m [128];
  always @(posedge clk) begin
    if (imem_wen) imem_m[imem_addr[8:2]] <= imem_wdata;
    if (dmem_ren) dmem_rdata <= dmem_m[dmem_addr[9:3]];
  end

  function automatic logic [31:0] pw(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic logic [63:0] dw(input int i);
    return {32'hDEAD_0000 | 32'(i), 32'hBEEF_0000 | 32'(i)};
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},   64'(busy),       64'd0);
    chk({tag, "_done"},   64'(done),       64'd0);
    chk({tag, "_arstn"},  64'(cpu_arst_n), 64'd0);
    chk({tag, "_enable"}, 64'(cpu_enable), 64'd0);
    chk({tag, "_ldrdy"},  64'(ld_ready),   64'd0);
    chk({tag, "_dvalid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_dren"},   64'(dmem_ren),   64'd0);
    chk({tag, "_ddata"},  dump_data,       64'd0);
    chk({tag, "_cycles"}, 64'(cycles_run), 64'd0);
  endtask

  // Per-job observations.
  logic [63:0] wen_addr[$];
  logic [31:0] wen_data[$];
  logic [63:0] ren_addr[$];
  logic [63:0] dq[$];
  int en_cnt, first_en, last_wen, done_cnt;

  // Issues one job and watches the DUT until one cycle after done
  // (or until the first dump_valid when abort_dump is set, which asserts rst).
  task automatic run_job(input int plen, input int rc, input int dlen,
                         input bit rdy_toggle, input bit abort_dump, input bit halt_at5);
    int cyc, li;
    bit fin;
    wen_addr.delete(); wen_data.delete(); ren_addr.delete(); dq.delete();
    en_cnt = 0; first_en = -1; last_wen = -1; done_cnt = 0;
    prog_len = 8'(plen); run_cycles = CNT_W'(rc); dump_len = 8'(dlen);
    start = 1'b1;
    tick();
    start = 1'b0;
    fin = 1'b0; cyc = 0; li = 0;
    while (!fin && cyc < BUDGET) begin
      ld_valid   = 1'b1;
      ld_data    = pw(li);
      dump_ready = rdy_toggle ? (cyc % 2 == 0) : 1'b1;
      instr_obs  = (halt_at5 && en_cnt == 4) ? 32'h0000_006F : 32'h0000_0013;
      @(negedge clk);
      if (imem_wen) begin
        wen_addr.push_back(imem_addr); wen_data.push_back(imem_wdata);
        last_wen = cyc; li++;
      end
      if (cpu_enable) begin
        if (en_cnt == 0) first_en = cyc;
        en_cnt++;
      end
      if (dmem_ren) ren_addr.push_back(dmem_addr);
      if (dump_valid && dump_ready) dq.push_back(dump_data);
      if (!done && done_cnt > 0) fin = 1'b1;
      if (done) done_cnt++;
      if (abort_dump && dump_valid) begin
        rst = 1'b1;
        fin = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("job_finished", 64'(fin), 64'd1);
    ld_valid = 1'b0; dump_ready = 1'b0; instr_obs = 32'h0000_0013;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_len = '0; run_cycles = '0; dump_len = '0;
    ld_valid = 1'b0; ld_data = '0; dump_ready = 1'b0; instr_obs = 32'h0000_0013;
    for (int i = 0; i < 128; i++) dmem_m[i] = dw(i);

    // Reset state.
    repeat (2) tick();
    @(negedge clk);
    chk_idle_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Reset while loading word 2.
    prog_len = 8'd5; run_cycles = CNT_W'(10); dump_len = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    ld_valid = 1'b1; ld_data = pw(0);
    tick();
    ld_data = pw(1);
    tick();
    ld_data = pw(2); rst = 1'b1;
    @(negedge clk);
    chk("abort_load_ready", 64'(ld_ready), 64'd1);
    chk("abort_load_addr",  imem_addr,     64'd8);
    tick();
    rst = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk_idle_zero("abort_load");
    tick();

    // Reset while presenting the first dump word.
    run_job(1, 2, 4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_idle_zero("abort_dump");
    rst = 1'b0;
    tick();

    // Full job: 3 words, 10 cycles, 4-word dump with toggling ready.
    run_job(3, 10, 4, 1'b1, 1'b0, 1'b0);
    chk("main_wen_count", 64'(wen_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("main_wen_addr%0d", i), (i < wen_addr.size()) ? wen_addr[i] : '1, 64'(4 * i));
      chk($sformatf("main_wen_data%0d", i), (i < wen_data.size()) ? 64'(wen_data[i]) : '1, 64'(pw(i)));
      chk($sformatf("main_imem%0d", i), 64'(imem_m[i]), 64'(pw(i)));
    end
    chk("main_run_follows_load", 64'(first_en), 64'(last_wen + 1));
    chk("main_enable_cycles", 64'(en_cnt), 64'd10);
    chk("main_cycles_run", 64'(cycles_run), 64'd10);
    chk("main_ren_count", 64'(ren_addr.size()), 64'd4);
    chk("main_dump_count", 64'(dq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("main_ren_addr%0d", i), (i < ren_addr.size()) ? ren_addr[i] : '1, 64'(8 * i));
      chk($sformatf("main_dump%0d", i), (i < dq.size()) ? dq[i] : '1, dw(i));
    end
    chk("main_done_pulses", 64'(done_cnt), 64'd1);
    chk("main_arstn_held", 64'(cpu_arst_n), 64'd1);
    chk("main_idle_busy", 64'(busy), 64'd0);

    // Zero run budget and zero dump: CPU never enabled.
    run_job(2, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("zero_wen_count", 64'(wen_addr.size()), 64'd2);
    chk("zero_enable_cycles", 64'(en_cnt), 64'd0);
    chk("zero_cycles_run", 64'(cycles_run), 64'd0);
    chk("zero_dump_count", 64'(dq.size()), 64'd0);
    chk("zero_done_pulses", 64'(done_cnt), 64'd1);

    // Empty program, dump length clamped to the data-memory depth.
    run_job(0, 3, 200, 1'b0, 1'b0, 1'b0);
    chk("clamp_wen_count", 64'(wen_addr.size()), 64'd0);
    chk("clamp_enable_cycles", 64'(en_cnt), 64'd3);
    chk("clamp_dump_count", 64'(dq.size()), 64'd128);
    chk("clamp_last_addr", (ren_addr.size() == 128) ? ren_addr[127] : '1, 64'd1016);
    chk("clamp_last_data", (dq.size() == 128) ? dq[127] : '1, dw(127));
    chk("clamp_done_pulses", 64'(done_cnt), 64'd1);

`ifdef CPU_SEQ_HALT_DETECT_EN
    // Halt fetched in the 5th RUN cycle of a 100-cycle budget.
    run_job(0, 100, 0, 1'b0, 1'b0, 1'b1);
    chk("halt_enable_cycles", 64'(en_cnt), 64'd5);
    chk("halt_cycles_run", 64'(cycles_run), 64'd5);
    chk("halt_flag", 64'(halted), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
